ascon_stream_io: RTL and testbench
==================================

// Module: ascon_stream_io
// PURPOSE
//  W-bit-lane streaming front end for the Ascon AEAD core. Collects key, nonce, AD, data and (decrypt) reference tag
//  over valid/ready beats, starts the core and unloads ciphertext/plaintext and tag over valid/ready beats.
//  Decrypt mode verifies the tag and suppresses plaintext release on mismatch.
//  Sits between the pad/serial interface and AsconCore, whose ports are exposed as core_*.
// PARAMETERS
//  K   128  key width (bits)
//  L   32   associated-data width
//  Y   200  message width
//  W   8    lane width per beat; legal 1,2,4,8. K, 128, L and Y must be multiples of W (elaboration error otherwise)
// PORTS
//  clk          in   1    clock
//  rst          in   1    synchronous reset, active-low
//  key_in       in   W    key lane
//  nonce_in     in   W    nonce lane
//  ad_in        in   W    AD lane
//  data_in      in   W    message lane
//  tagref_in    in   W    reference-tag lane (decrypt)
//  in_valid     in   1    input beat valid
//  in_ready     out  1    input beat accepted when in_valid & in_ready
//  start        in   1    start request
//  decrypt      in   1    mode, sampled with start (1 = decrypt)
//  out_data     out  W    data lane
//  out_tag      out  W    tag lane
//  out_valid    out  1    output beat valid
//  out_ready    in   1    output beat consumed when out_valid & out_ready
//  busy         out  1    high in ARMED/RUN/UNLOAD
//  done         out  1    1-cycle pulse after the final output beat
//  tag_ok       out  1    decrypt: core tag == reference tag; held until next start
//  core_key/core_nonce/core_ad/core_data  out  K/128/L/Y  held operands to core
//  core_start   out  1    1-cycle start pulse to core
//  core_decrypt out  1    latched mode
//  core_out     in   Y    core result
//  core_tag     in   128  core tag
//  core_ready   in   1    core result valid
// BEHAVIOUR
//  Reset (rst=0 at posedge): state LOAD; all registers and counters cleared; outputs 0. in_ready is 0 while rst=0.
//  Reset mid-operation aborts everything: no core_start, no done.
//  NIN = max(K,128,L,Y)/W beats; NOUT = max(Y,128)/W beats.
//  Every field shifts MSB-first: reg <= {reg[F-W-1:0], lane}, only while beat index < F/W;
//   lanes of a shorter field are ignored after that field is full.
//  LOAD: in_ready=1. Accepted beat increments beat count. After beat NIN -> ARMED. start is ignored in LOAD,
//   including in the cycle of the last beat.
//  ARMED: in_ready=0. On start=1: latch decrypt, assert core_start for exactly the next cycle, clear tag_ok -> RUN.
//  RUN: core_ready is ignored in the core_start cycle and sampled from the following cycle. On core_ready=1:
//   latch core_out into the data shifter and core_tag into the tag shifter.
//   If decrypt: tag_ok <= (core_tag == reference tag); on mismatch the data shifter is loaded with 0. -> UNLOAD.
//  UNLOAD: out_valid=1. out_data = data shifter[Y-1 -: W] and out_tag = tag shifter[127 -: W]; both are 0 once
//   their field is exhausted (beat >= Y/W or 128/W). On a handshake both shift left by W.
//   out_data/out_tag are stable while out_valid & !out_ready. On beat NOUT: done=1 for one cycle, out_valid=0,
//   counters cleared -> LOAD. Input and tag registers are cleared. tag_ok and core_decrypt hold.
//  core_* operands are stable from ARMED until UNLOAD exits.
//  in_valid outside LOAD and start outside ARMED have no effect. in_valid & start in the same cycle: each acts only
//   in its own state.
//  Encrypt: tag_ok stays 0.
// TESTING
//  W=8, encrypt: load 25 beats with key=0x000102..0F, nonce=0x101112..1F -> core_key/core_nonce match bit-exact;
//   a model core answers 4 cycles after core_start; 25 data beats and 16 tag beats, MSB first; done pulses once.
//  Decrypt, matching tagref -> tag_ok=1, plaintext released unchanged.
//  Decrypt, tagref with LSB flipped -> tag_ok=0, all 25 out_data beats = 0x00, tag is still emitted.
//  Backpressure: out_ready random at 30% -> no beat dropped or duplicated; out_data stable while stalled.
//  start pulsed during LOAD and in the cycle of the last beat -> ignored; start at ARMED+3 -> one core_start.
//  rst=0 during UNLOAD beat 10 -> the next cycle has out_valid=0 and state LOAD; a fresh full run then passes.
//   W=1 and W=4 regressions repeat the first scenario.

Source files
------------

// File: rtl/ascon_stream_io.sv
// ascon_stream_io: lane-serial front end for the Ascon AEAD core.
// Shifts key, nonce, AD, message and reference tag in W bits per beat,
// arms and starts the core, then shifts the result and tag out W bits per
// beat. In decrypt mode a tag mismatch blanks the released plaintext.
module ascon_stream_io #(
    parameter int K = 128,
    parameter int L = 32,
    parameter int Y = 200,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] key_in,
    input  logic [W-1:0] nonce_in,
    input  logic [W-1:0] ad_in,
    input  logic [W-1:0] data_in,
    input  logic [W-1:0] tagref_in,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         start,
    input  logic         decrypt,
    output logic [W-1:0] out_data,
    output logic [W-1:0] out_tag,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy,
    output logic         done,
    output logic         tag_ok,
    output logic [K-1:0] core_key,
    output logic [127:0] core_nonce,
    output logic [L-1:0] core_ad,
    output logic [Y-1:0] core_data,
    output logic         core_start,
    output logic         core_decrypt,
    input  logic [Y-1:0] core_out,
    input  logic [127:0] core_tag,
    input  logic         core_ready
);

    localparam int T      = 128;
    localparam int MAX_KT = (K > T) ? K : T;
    localparam int MAX_LY = (L > Y) ? L : Y;
    localparam int NIN    = ((MAX_KT > MAX_LY) ? MAX_KT : MAX_LY) / W;
    localparam int NOUT   = ((Y > T) ? Y : T) / W;
    localparam int ICW    = $clog2(NIN + 1);
    localparam int OCW    = $clog2(NOUT + 1);

    localparam logic [ICW-1:0] NIN_C = ICW'(NIN);
    localparam logic [ICW-1:0] KB_C  = ICW'(K / W);
    localparam logic [ICW-1:0] NB_C  = ICW'(T / W);
    localparam logic [ICW-1:0] AB_C  = ICW'(L / W);
    localparam logic [ICW-1:0] DB_C  = ICW'(Y / W);
    localparam logic [OCW-1:0] NOUT_C = OCW'(NOUT);
    localparam logic [OCW-1:0] YB_C   = OCW'(Y / W);
    localparam logic [OCW-1:0] TB_C   = OCW'(T / W);

    // Lane width must be a power of two up to 8 and divide every field.
    generate
        if (!(W == 1 || W == 2 || W == 4 || W == 8) ||
            (K % W) != 0 || (T % W) != 0 || (L % W) != 0 || (Y % W) != 0) begin : g_param_check
            $error("ascon_stream_io: W must be 1,2,4,8 and divide K, 128, L and Y");
        end
    endgenerate

    typedef enum logic [1:0] {S_LOAD, S_ARMED, S_RUN, S_UNLOAD} state_t;

    state_t         state_q, state_d;
    logic [ICW-1:0] in_cnt_q;
    logic [OCW-1:0] out_cnt_q;
    logic [K-1:0]   key_q;
    logic [T-1:0]   nonce_q;
    logic [L-1:0]   ad_q;
    logic [Y-1:0]   data_q;
    logic [T-1:0]   tagref_q;
    logic [Y-1:0]   dsh_q;
    logic [T-1:0]   tsh_q;
    logic           core_start_q;
    logic           decrypt_q;
    logic           tag_ok_q;
    logic           done_q;

    logic in_hs, out_hs, last_in, last_out, start_go, core_hit, tag_match;

    assign in_hs     = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;
    assign last_in   = in_hs && (in_cnt_q == NIN_C - ICW'(1));
    assign last_out  = out_hs && (out_cnt_q == NOUT_C - OCW'(1));
    assign start_go  = (state_q == S_ARMED) && start;
    // The core's answer is only trusted once the start pulse has gone.
    assign core_hit  = (state_q == S_RUN) && !core_start_q && core_ready;
    assign tag_match = (core_tag == tagref_q);

    // State register; reset returns to LOAD and abandons any run in flight.
    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_LOAD;
        else      state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_LOAD: begin
                in_ready = rst;
                busy     = 1'b0;
                if (last_in) state_d = S_ARMED;
            end
            S_ARMED:  if (start) state_d = S_RUN;
            S_RUN:    if (core_hit) state_d = S_UNLOAD;
            S_UNLOAD: begin
                out_valid = 1'b1;
                if (last_out) state_d = S_LOAD;
            end
            default:  state_d = S_LOAD;
        endcase
    end

    // Input shifters: each field takes only its first F/W lanes, MSB first.
    always_ff @(posedge clk) begin
        if (!rst || last_out) begin
            in_cnt_q <= '0;
            key_q    <= '0;
            nonce_q  <= '0;
            ad_q     <= '0;
            data_q   <= '0;
            tagref_q <= '0;
        end else if (in_hs) begin
            in_cnt_q <= in_cnt_q + ICW'(1);
            if (in_cnt_q < KB_C) key_q    <= K'({key_q, key_in});
            if (in_cnt_q < NB_C) nonce_q  <= T'({nonce_q, nonce_in});
            if (in_cnt_q < AB_C) ad_q     <= L'({ad_q, ad_in});
            if (in_cnt_q < DB_C) data_q   <= Y'({data_q, data_in});
            if (in_cnt_q < NB_C) tagref_q <= T'({tagref_q, tagref_in});
        end
    end

    // Core handshake: one-cycle start pulse, latched mode and tag verdict.
    always_ff @(posedge clk) begin
        if (!rst) begin
            core_start_q <= 1'b0;
            decrypt_q    <= 1'b0;
            tag_ok_q     <= 1'b0;
        end else begin
            core_start_q <= start_go;
            if (start_go) begin
                decrypt_q <= decrypt;
                tag_ok_q  <= 1'b0;
            end else if (core_hit && decrypt_q) begin
                tag_ok_q  <= tag_match;
            end
        end
    end

    // Output shifters: capture the core result, then shift out per handshake.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dsh_q     <= '0;
            tsh_q     <= '0;
            out_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= last_out;
            if (core_hit) begin
                dsh_q <= (decrypt_q && !tag_match) ? '0 : core_out;
                tsh_q <= core_tag;
            end else if (last_out) begin
                dsh_q     <= '0;
                tsh_q     <= '0;
                out_cnt_q <= '0;
            end else if (out_hs) begin
                dsh_q     <= dsh_q << W;
                tsh_q     <= tsh_q << W;
                out_cnt_q <= out_cnt_q + OCW'(1);
            end
        end
    end

    assign out_data     = (out_valid && out_cnt_q < YB_C) ? dsh_q[Y-1 -: W] : '0;
    assign out_tag      = (out_valid && out_cnt_q < TB_C) ? tsh_q[T-1 -: W] : '0;
    assign done         = done_q;
    assign tag_ok       = tag_ok_q;
    assign core_key     = key_q;
    assign core_nonce   = nonce_q;
    assign core_ad      = ad_q;
    assign core_data    = data_q;
    assign core_start   = core_start_q;
    assign core_decrypt = decrypt_q;

endmodule

// File: tb/tb_ascon_stream_io.sv
// Bench for ascon_stream_io: W=8, W=1 and W=4 instances share one stimulus
// path selected by sel; a model core answers 4 cycles after core_start.
module tb_ascon_stream_io;

    localparam int K = 128;
    localparam int L = 32;
    localparam int Y = 200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [7:0] key_l = '0, nonce_l = '0, ad_l = '0, data_l = '0, tagref_l = '0;
    logic       in_valid_x = 1'b0, start_x = 1'b0, decrypt_x = 1'b0, out_ready_x = 1'b0;
    logic [Y-1:0] resp_out = '0;
    logic [127:0] resp_tag = '0;
    logic         core_ready_x;

    logic [2:0]   in_ready_v, out_valid_v, busy_v, done_v, tag_ok_v, core_start_v, core_decrypt_v;
    logic [K-1:0] core_key_a   [3];
    logic [127:0] core_nonce_a [3];
    logic [L-1:0] core_ad_a    [3];
    logic [Y-1:0] core_data_a  [3];
    logic [7:0]   od8, ot8;
    logic [0:0]   od1, ot1;
    logic [3:0]   od4, ot4;

    int n_err = 0;
    int n_chk = 0;
    int done_cnt = 0;
    int core_start_cnt = 0;

    ascon_stream_io #(.K(K), .L(L), .Y(Y), .W(8)) u_w8 (
        .clk(clk), .rst(rst),
        .key_in(key_l), .nonce_in(nonce_l), .ad_in(ad_l), .data_in(data_l), .tagref_in(tagref_l),
        .in_valid(in_valid_x && sel == 2'd0), .in_ready(in_ready_v[0]),
        .start(start_x && sel == 2'd0), .decrypt(decrypt_x),
        .out_data(od8), .out_tag(ot8), .out_valid(out_valid_v[0]), .out_ready(out_ready_x && sel == 2'd0),
        .busy(busy_v[0]), .done(done_v[0]), .tag_ok(tag_ok_v[0]),
        .core_key(core_key_a[0]), .core_nonce(core_nonce_a[0]), .core_ad(core_ad_a[0]), .core_data(core_data_a[0]),
        .core_start(core_start_v[0]), .core_decrypt(core_decrypt_v[0]),
        .core_out(resp_out), .core_tag(resp_tag), .core_ready(core_ready_x && sel == 2'd0)
    );

    ascon_stream_io #(.K(K), .L(L), .Y(Y), .W(1)) u_w1 (
        .clk(clk), .rst(rst),
        .key_in(key_l[0]), .nonce_in(nonce_l[0]), .ad_in(ad_l[0]), .data_in(data_l[0]), .tagref_in(tagref_l[0]),
        .in_valid(in_valid_x && sel == 2'd1), .in_ready(in_ready_v[1]),
        .start(start_x && sel == 2'd1), .decrypt(decrypt_x),
        .out_data(od1), .out_tag(ot1), .out_valid(out_valid_v[1]), .out_ready(out_ready_x && sel == 2'd1),
        .busy(busy_v[1]), .done(done_v[1]), .tag_ok(tag_ok_v[1]),
        .core_key(core_key_a[1]), .core_nonce(core_nonce_a[1]), .core_ad(core_ad_a[1]), .core_data(core_data_a[1]),
        .core_start(core_start_v[1]), .core_decrypt(core_decrypt_v[1]),
        .core_out(resp_out), .core_tag(resp_tag), .core_ready(core_ready_x && sel == 2'd1)
    );

    ascon_stream_io #(.K(K), .L(L), .Y(Y), .W(4)) u_w4 (
        .clk(clk), .rst(rst),
        .key_in(key_l[3:0]), .nonce_in(nonce_l[3:0]), .ad_in(ad_l[3:0]), .data_in(data_l[3:0]), .tagref_in(tagref_l[3:0]),
        .in_valid(in_valid_x && sel == 2'd2), .in_ready(in_ready_v[2]),
        .start(start_x && sel == 2'd2), .decrypt(decrypt_x),
        .out_data(od4), .out_tag(ot4), .out_valid(out_valid_v[2]), .out_ready(out_ready_x && sel == 2'd2),
        .busy(busy_v[2]), .done(done_v[2]), .tag_ok(tag_ok_v[2]),
        .core_key(core_key_a[2]), .core_nonce(core_nonce_a[2]), .core_ad(core_ad_a[2]), .core_data(core_data_a[2]),
        .core_start(core_start_v[2]), .core_decrypt(core_decrypt_v[2]),
        .core_out(resp_out), .core_tag(resp_tag), .core_ready(core_ready_x && sel == 2'd2)
    );

    // View of the instance under test.
    logic [7:0]   m_out_data, m_out_tag;
    logic         m_in_ready, m_out_valid, m_busy, m_done, m_tag_ok, m_core_start, m_core_decrypt;
    logic [K-1:0] m_core_key;
    logic [127:0] m_core_nonce;
    logic [L-1:0] m_core_ad;
    logic [Y-1:0] m_core_data;
    int           si;
    assign si             = (sel == 2'd1) ? 1 : (sel == 2'd2) ? 2 : 0;
    assign m_out_data     = (sel == 2'd1) ? 8'(od1) : (sel == 2'd2) ? 8'(od4) : od8;
    assign m_out_tag      = (sel == 2'd1) ? 8'(ot1) : (sel == 2'd2) ? 8'(ot4) : ot8;
    assign m_in_ready     = in_ready_v[si];
    assign m_out_valid    = out_valid_v[si];
    assign m_busy         = busy_v[si];
    assign m_done         = done_v[si];
    assign m_tag_ok       = tag_ok_v[si];
    assign m_core_start   = core_start_v[si];
    assign m_core_decrypt = core_decrypt_v[si];
    assign m_core_key     = core_key_a[si];
    assign m_core_nonce   = core_nonce_a[si];
    assign m_core_ad      = core_ad_a[si];
    assign m_core_data    = core_data_a[si];

    // Model core: result valid for one cycle, 4 cycles after core_start.
    logic [2:0] cm_cnt;
    always @(posedge clk) begin
        if (!rst)                           cm_cnt <= 3'd0;
        else if (m_core_start)              cm_cnt <= 3'd1;
        else if (cm_cnt != 0 && cm_cnt < 4) cm_cnt <= cm_cnt + 3'd1;
        else                                cm_cnt <= 3'd0;
    end
    assign core_ready_x = (cm_cnt == 3'd4);

    always @(posedge clk) begin
        if (m_done)       done_cnt       <= done_cnt + 1;
        if (m_core_start) core_start_cnt <= core_start_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [199:0] rnd200();
        logic [223:0] t = '0;
        for (int i = 0; i < 7; i++) t = {t[191:0], $urandom};
        return t[199:0];
    endfunction

    // Beat b of field v (F bits, MSB first) at lane width w; 0 past the field.
    function automatic logic [7:0] seg(input logic [199:0] v, input int f, input int w, input int b);
        logic [199:0] t;
        if (b >= f / w) return 8'h00;
        t = v >> (f - (b + 1) * w);
        return t[7:0] & 8'((1 << w) - 1);
    endfunction

    function automatic logic [7:0] lane(input logic [199:0] v, input int f, input int w, input int b);
        if (b >= f / w) return 8'($urandom);
        return seg(v, f, w, b);
    endfunction

    task automatic run(input logic [1:0] s, input bit dec, input bit flip, input int rdy_pct,
                       input int rst_beat, input bit fixed_kn);
        int w, nin, nout, beat, cyc, c0, d0;
        bit stalled, aborted;
        logic [7:0] prev_d, prev_t, exp_d, exp_t;
        logic [199:0] key_v, nonce_v, ad_v, data_v, tagref_v;
        w    = (s == 2'd1) ? 1 : (s == 2'd2) ? 4 : 8;
        sel  = s;
        nin  = Y / w;
        nout = Y / w;
        key_v    = fixed_kn ? 200'(128'h000102030405060708090a0b0c0d0e0f) : 200'(rnd200() & 200'({128{1'b1}}));
        nonce_v  = fixed_kn ? 200'(128'h101112131415161718191a1b1c1d1e1f) : 200'(rnd200() & 200'({128{1'b1}}));
        ad_v     = 200'($urandom);
        data_v   = rnd200();
        resp_out = rnd200();
        resp_tag = 128'(rnd200());
        tagref_v = dec ? 200'(resp_tag ^ 128'(flip)) : 200'(128'(rnd200()));
        c0 = core_start_cnt;
        d0 = done_cnt;

        // Load phase with random idle gaps; start is pulsed and must be ignored.
        for (int b = 0; b < nin; b++) begin
            @(negedge clk);
            if ($urandom_range(0, 4) == 0) begin
                in_valid_x = 1'b0;
                start_x    = 1'b1;
                @(negedge clk);
            end
            key_l      = lane(key_v, K, w, b);
            nonce_l    = lane(nonce_v, 128, w, b);
            ad_l       = lane(ad_v, L, w, b);
            data_l     = lane(data_v, Y, w, b);
            tagref_l   = lane(tagref_v, 128, w, b);
            in_valid_x = 1'b1;
            start_x    = (b == nin - 1) || (b % 9 == 4);
            decrypt_x  = 1'b1;
            if (b == 0) check_eq("in_ready_load", m_in_ready, 1'b1);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid_x = 1'b0;
        start_x    = 1'b0;
        check_eq("armed_busy", m_busy, 1'b1);
        check_eq("armed_in_ready", m_in_ready, 1'b0);
        check_eq("no_early_start", core_start_cnt, c0);
        repeat (2) @(negedge clk);
        check_eq("armed_core_start", m_core_start, 1'b0);
        start_x    = 1'b1;
        decrypt_x  = dec;
        in_valid_x = 1'b1;
        key_l      = 8'($urandom);
        @(negedge clk);
        start_x    = 1'b0;
        decrypt_x  = !dec;
        in_valid_x = 1'b0;
        check_eq("core_start_pulse", m_core_start, 1'b1);
        check_eq("core_decrypt", m_core_decrypt, dec);
        check_eq("core_key", m_core_key, key_v);
        check_eq("core_nonce", m_core_nonce, nonce_v);
        check_eq("core_ad", m_core_ad, ad_v);
        check_eq("core_data", m_core_data, data_v);
        @(negedge clk);
        check_eq("core_start_once", m_core_start, 1'b0);

        // Unload phase with optional backpressure and optional mid-run reset.
        beat = 0; cyc = 0; stalled = 1'b0; aborted = 1'b0;
        prev_d = '0; prev_t = '0;
        while (beat < nout && cyc < 4000 && !aborted) begin
            @(negedge clk);
            cyc++;
            if (m_out_valid) begin
                if (stalled) begin
                    check_eq("stall_data", m_out_data, prev_d);
                    check_eq("stall_tag", m_out_tag, prev_t);
                end
                if (beat == rst_beat) begin
                    out_ready_x = 1'b0;
                    rst = 1'b0;
                    @(negedge clk);
                    check_eq("rst_out_valid", m_out_valid, 1'b0);
                    check_eq("rst_busy", m_busy, 1'b0);
                    check_eq("rst_in_ready", m_in_ready, 1'b0);
                    check_eq("rst_tag_ok", m_tag_ok, 1'b0);
                    rst = 1'b1;
                    repeat (3) @(negedge clk);
                    check_eq("rst_no_done", done_cnt, d0);
                    check_eq("rst_in_ready_back", m_in_ready, 1'b1);
                    aborted = 1'b1;
                end else begin
                    out_ready_x = ($urandom_range(0, 99) < rdy_pct);
                    if (out_ready_x) begin
                        exp_d = (dec && flip) ? 8'h00 : seg(resp_out, Y, w, beat);
                        exp_t = seg(200'(resp_tag), 128, w, beat);
                        check_eq($sformatf("w%0d_data[%0d]", w, beat), m_out_data, exp_d);
                        check_eq($sformatf("w%0d_tag[%0d]", w, beat), m_out_tag, exp_t);
                        beat++;
                    end
                    stalled = !out_ready_x;
                    prev_d  = m_out_data;
                    prev_t  = m_out_tag;
                end
            end else begin
                out_ready_x = 1'($urandom_range(0, 1));
            end
        end
        if (!aborted) begin
            check_eq("unload_beats", beat, nout);
            @(negedge clk);
            out_ready_x = 1'b0;
            check_eq("done_pulse", m_done, 1'b1);
            check_eq("done_out_valid", m_out_valid, 1'b0);
            check_eq("done_busy", m_busy, 1'b0);
            check_eq("tag_ok", m_tag_ok, dec && !flip);
            check_eq("decrypt_hold", m_core_decrypt, dec);
            check_eq("key_cleared", m_core_key, '0);
            @(negedge clk);
            check_eq("done_low", m_done, 1'b0);
            check_eq("done_count", done_cnt, d0 + 1);
            check_eq("core_start_count", core_start_cnt, c0 + 1);
        end
        $display("run w=%0d dec=%0d flip=%0d rdy=%0d%% rst_beat=%0d beats=%0d errors=%0d",
                 w, dec, flip, rdy_pct, rst_beat, beat, n_err);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready_all", in_ready_v, 3'b000);
        check_eq("rst_out_valid_all", out_valid_v, 3'b000);
        check_eq("rst_busy_all", busy_v, 3'b000);
        check_eq("rst_done_all", done_v, 3'b000);
        check_eq("rst_tag_ok_all", tag_ok_v, 3'b000);
        check_eq("rst_core_start_all", core_start_v, 3'b000);
        check_eq("rst_core_key", m_core_key, '0);
        check_eq("rst_out_data", m_out_data, '0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("in_ready_after_rst", in_ready_v, 3'b111);

        run(2'd0, 1'b0, 1'b0, 100, -1, 1'b1);  // encrypt, fixed key/nonce
        run(2'd0, 1'b1, 1'b0, 100, -1, 1'b0);  // decrypt, matching tag
        run(2'd0, 1'b1, 1'b1, 100, -1, 1'b0);  // decrypt, tag LSB flipped
        run(2'd0, 1'b0, 1'b0, 30,  -1, 1'b0);  // backpressure
        run(2'd0, 1'b1, 1'b0, 30,  -1, 1'b0);  // decrypt with backpressure
        run(2'd0, 1'b1, 1'b0, 60,  10, 1'b0);  // reset at unload beat 10
        run(2'd0, 1'b0, 1'b0, 100, -1, 1'b1);  // fresh run after abort
        run(2'd1, 1'b0, 1'b0, 100, -1, 1'b1);  // W=1
        run(2'd2, 1'b0, 1'b0, 100, -1, 1'b1);  // W=4

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

endmodule
